// File: rtl/bip_memory_system_if.sv
// CPU/loader/dump-side signal bundle of the BIP memory responder.
// Signal names follow the memory's point of view (i_ = into memory, o_ = out of memory).
interface bip_mem_if #(
  parameter int NB_INSTRUC = 16,
  parameter int NB_ADDR    = 11,
  parameter int NB_DATA    = 16
);
  logic                  i_load_valid;
  logic [NB_INSTRUC-1:0] i_load_word;
  logic                  i_load_last;
  logic                  o_load_ready;
  logic [NB_ADDR-1:0]    i_addr_program_mem;
  logic [NB_INSTRUC-1:0] o_instruc;
  logic [NB_ADDR-1:0]    i_addr_data_mem;
  logic [NB_DATA-1:0]    i_data_memory;
  logic                  i_WrRam;
  logic                  i_RdRam;
  logic [NB_DATA-1:0]    o_data_memory;
  logic                  o_cpu_rst;
  logic                  o_halted;
  logic                  i_dump_req;
  logic                  o_dump_valid;
  logic [NB_DATA-1:0]    o_dump_data;
  logic                  o_dump_last;
  logic                  i_dump_ready;

  modport slave (
    input  i_load_valid, i_load_word, i_load_last,
    output o_load_ready,
    input  i_addr_program_mem,
    output o_instruc,
    input  i_addr_data_mem, i_data_memory, i_WrRam, i_RdRam,
    output o_data_memory, o_cpu_rst, o_halted,
    input  i_dump_req,
    output o_dump_valid, o_dump_data, o_dump_last,
    input  i_dump_ready
  );

  modport master (
    output i_load_valid, i_load_word, i_load_last,
    input  o_load_ready,
    output i_addr_program_mem,
    input  o_instruc,
    output i_addr_data_mem, i_data_memory, i_WrRam, i_RdRam,
    input  o_data_memory, o_cpu_rst, o_halted,
    output i_dump_req,
    input  o_dump_valid, o_dump_data, o_dump_last,
    output i_dump_ready
  );
endinterface

// File: rtl/bip_memory_system.sv
// BIP program/data memory: boots from a load stream while zeroing data memory,
// runs the CPU until HALT, then streams data memory out on request.
module bip_memory_system #(
  parameter int                NB_INSTRUC  = 16,
  parameter int                NB_OPCODE   = 5,
  parameter int                NB_ADDR     = 11,
  parameter int                NB_DATA     = 16,
  parameter int                DATA_DEPTH  = 1024,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 5'b00000
) (
  input  logic     i_clk,
  input  logic     i_rst,
  bip_mem_if.slave io_mem
);

  localparam int PROG_DEPTH = 2**NB_ADDR;
  localparam int NB_DPTR    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [NB_DPTR-1:0] LAST_DPTR = NB_DPTR'(DATA_DEPTH - 1);
  localparam logic [NB_ADDR:0]   DEPTH_LIM = (NB_ADDR + 1)'(DATA_DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT, S_DUMP} state_t;

  state_t r_state, w_state_next;

  logic [NB_INSTRUC-1:0] r_prog_mem [PROG_DEPTH];
  logic [NB_DATA-1:0]    r_data_mem [DATA_DEPTH];

  logic [NB_ADDR-1:0]    r_load_ptr;
  logic                  r_load_done;
  logic                  r_load_ready;
  logic [NB_DPTR-1:0]    r_clear_ptr;
  logic                  r_clear_done;
  logic                  r_halt_en;
  logic [NB_INSTRUC-1:0] r_instruc;
  logic [NB_DATA-1:0]    r_data_out;
  logic [NB_DPTR-1:0]    r_dump_ptr;
  logic                  r_dump_valid;
  logic [NB_DATA-1:0]    r_dump_data;
  logic                  r_dump_last;

  logic                  w_load_acc;
  logic                  w_addr_ok;
  logic [NB_DPTR-1:0]    w_daddr;
  logic                  w_dump_start;
  logic                  w_dump_fetch;
  logic                  w_dump_done;
  logic                  w_dm_we;
  logic [NB_DPTR-1:0]    w_dm_waddr;
  logic [NB_DATA-1:0]    w_dm_wdata;

  assign w_load_acc   = (r_state == S_LOAD) && r_load_ready && io_mem.i_load_valid;
  assign w_addr_ok    = ({1'b0, io_mem.i_addr_data_mem} < DEPTH_LIM);
  assign w_daddr      = io_mem.i_addr_data_mem[NB_DPTR-1:0];
  assign w_dump_start = (r_state == S_HALT) && io_mem.i_dump_req;
  // A word is fetched on DUMP entry (nothing valid yet) and on each non-final handshake.
  assign w_dump_fetch = (r_state == S_DUMP) &&
                        (!r_dump_valid || (io_mem.i_dump_ready && !r_dump_last));
  assign w_dump_done  = (r_state == S_DUMP) && r_dump_valid && io_mem.i_dump_ready && r_dump_last;

  always_comb begin
    w_dm_we    = 1'b0;
    w_dm_waddr = r_clear_ptr;
    w_dm_wdata = '0;
    if ((r_state == S_LOAD) && !r_clear_done) begin
      w_dm_we = 1'b1;
    end else if ((r_state == S_RUN) && io_mem.i_WrRam && w_addr_ok) begin
      w_dm_we    = 1'b1;
      w_dm_waddr = w_daddr;
      w_dm_wdata = io_mem.i_data_memory;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_dm_we)    r_data_mem[w_dm_waddr] <= w_dm_wdata;
    if (w_load_acc) r_prog_mem[r_load_ptr] <= io_mem.i_load_word;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_LOAD;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD: if (r_load_done && r_clear_done) w_state_next = S_RUN;
      S_RUN:  if (r_halt_en && (r_instruc[NB_INSTRUC-1 -: NB_OPCODE] == HALT_OPCODE))
                w_state_next = S_HALT;
      S_HALT: if (io_mem.i_dump_req) w_state_next = S_DUMP;
      S_DUMP: if (w_dump_done) w_state_next = S_HALT;
      default: w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_load_ptr   <= '0;
      r_load_done  <= 1'b0;
      r_load_ready <= 1'b1;
    end else if (w_load_acc) begin
      r_load_ptr <= r_load_ptr + 1'b1;
      if (io_mem.i_load_last || (r_load_ptr == '1)) begin
        r_load_done  <= 1'b1;
        r_load_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clear_ptr  <= '0;
      r_clear_done <= 1'b0;
    end else if ((r_state == S_LOAD) && !r_clear_done) begin
      if (r_clear_ptr == LAST_DPTR) r_clear_done <= 1'b1;
      else                          r_clear_ptr  <= r_clear_ptr + 1'b1;
    end
  end

  // o_instruc in the first RUN cycle still reflects a fetch made during LOAD,
  // so HALT decoding waits one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_halt_en  <= 1'b0;
      r_instruc  <= '0;
      r_data_out <= '0;
    end else begin
      r_halt_en <= (r_state == S_RUN);
      r_instruc <= r_prog_mem[io_mem.i_addr_program_mem];
      if ((r_state == S_RUN) && io_mem.i_RdRam)
        r_data_out <= w_addr_ok ? r_data_mem[w_daddr] : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dump_ptr   <= '0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_last  <= 1'b0;
    end else if (w_dump_start) begin
      r_dump_ptr   <= '0;
      r_dump_valid <= 1'b0;
      r_dump_last  <= 1'b0;
    end else if (w_dump_fetch) begin
      r_dump_data  <= r_data_mem[r_dump_ptr];
      r_dump_last  <= (r_dump_ptr == LAST_DPTR);
      r_dump_valid <= 1'b1;
      r_dump_ptr   <= r_dump_ptr + 1'b1;
    end else if (w_dump_done) begin
      r_dump_valid <= 1'b0;
      r_dump_last  <= 1'b0;
    end
  end

  assign io_mem.o_load_ready  = r_load_ready;
  assign io_mem.o_instruc     = r_instruc;
  assign io_mem.o_data_memory = r_data_out;
  assign io_mem.o_cpu_rst     = (r_state != S_RUN);
  assign io_mem.o_halted      = (r_state == S_HALT) || (r_state == S_DUMP);
  assign io_mem.o_dump_valid  = r_dump_valid;
  assign io_mem.o_dump_data   = r_dump_data;
  assign io_mem.o_dump_last   = r_dump_last;

endmodule

// File: doc/bip_memory_system.md
Name: bip_memory_system

Overview:
Memory-side responder for the BIP CPU. It holds program and data memory, serves instruction fetches and data loads/stores issued by the CPU, and boots the system through a load stream. It then holds the CPU in reset until the program is loaded, detects HALT, and streams data memory contents out on request. It sits beside the CPU top level, inside the board-level wrapper that also contains the loader.

Parameters:
NB_INSTRUC, 16, instruction word width
NB_OPCODE, 5, opcode field width; the opcode is instruction bits [NB_INSTRUC-1 -: NB_OPCODE]
NB_ADDR, 11, program and data address width; program depth is 2**NB_ADDR
NB_DATA, 16, data word width
DATA_DEPTH, 1024, implemented data words; must be <= 2**NB_ADDR
HALT_OPCODE, 5'b00000, opcode that stops execution

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_load_valid  in  1  load word valid
i_load_word  in  NB_INSTRUC  program word to store
i_load_last  in  1  final program word
o_load_ready  out  1  load word accepted when valid && ready
i_addr_program_mem  in  NB_ADDR  CPU fetch address
o_instruc  out  NB_INSTRUC  fetched instruction
i_addr_data_mem  in  NB_ADDR  CPU data address
i_data_memory  in  NB_DATA  CPU store data
i_WrRam  in  1  CPU store strobe
i_RdRam  in  1  CPU load strobe
o_data_memory  out  NB_DATA  load data to CPU
o_cpu_rst  out  1  reset to CPU, high except in RUN
o_halted  out  1  HALT reached
i_dump_req  in  1  start data memory dump; single-cycle pulse, honoured only in HALT
o_dump_valid  out  1  dump word valid
o_dump_data  out  NB_DATA  dump word
o_dump_last  out  1  final dump word
i_dump_ready  in  1  dump word consumed when valid && ready

Behaviour:
- Reset values: state LOAD, o_load_ready=1, o_cpu_rst=1, o_instruc=0, o_data_memory=0, o_halted=0, o_dump_valid=0, o_dump_data=0, o_dump_last=0. Load, clear and dump pointers are 0.
- FSM states: LOAD, RUN, HALT, DUMP. Only i_rst returns the FSM to LOAD.
- LOAD:
  - Each valid&&ready edge writes prog_mem[load_ptr] and increments load_ptr.
  - load_done is set on acceptance of the word with i_load_last, or on acceptance at load_ptr = 2**NB_ADDR-1. On that same edge o_load_ready falls and stays low until reset.
  - In parallel, clear_ptr zeroes one data word per cycle from address 0 to DATA_DEPTH-1. clear_done is set after the last word.
  - Transition to RUN on the first edge where the registered load_done and clear_done are both 1.
- Fetch: o_instruc <= prog_mem[i_addr_program_mem] every edge in every state (1-cycle latency). Program memory is not cleared; unloaded locations are undefined.
- RUN: o_cpu_rst=0.
  - Store: on an edge with i_WrRam and addr < DATA_DEPTH, write data_mem. Stores at addr >= DATA_DEPTH are dropped.
  - Load: on an edge with i_RdRam, o_data_memory <= data_mem[addr], or 0 when addr >= DATA_DEPTH. Otherwise o_data_memory holds its value. Latency is 1 cycle.
  - Simultaneous read and write to the same address is read-first: the old data is returned.
  - HALT detection is enabled from the 2nd RUN cycle. When o_instruc opcode == HALT_OPCODE, the next state is HALT.
- HALT: o_halted=1, o_cpu_rst=1. CPU strobes are ignored. An i_dump_req pulse moves the FSM to DUMP with dump_ptr=0.
- DUMP:
  - o_dump_valid rises one cycle after entry, with o_dump_data = data_mem[0].
  - While valid && !ready, o_dump_data and o_dump_last are held stable.
  - On valid && ready, the next word is presented on the following cycle (prefetched, so there are no bubbles while ready stays high).
  - o_dump_last=1 with word DATA_DEPTH-1. Its acceptance drops valid and returns the FSM to HALT.
  - i_dump_req is ignored while in DUMP; a later pulse in HALT repeats the dump.
- Reset asserted mid-operation (any state) immediately forces all reset values and aborts the load, clear or dump.

Test Plan:
1. Reset; load 0x0801, 0x1802, 0x0000 with last on the 3rd word and a 2-cycle valid gap -> o_load_ready falls on the 3rd acceptance. o_cpu_rst falls after DATA_DEPTH clear cycles. In RUN, o_instruc = 0x0801 one cycle after fetch address 0.
2. In RUN: WrRam addr 5 data 0xBEEF, then RdRam addr 5 -> o_data_memory=0xBEEF the next cycle. Simultaneous Wr 0x1234 and Rd at addr 6 -> returns 0, and a later Rd returns 0x1234. Wr/Rd at addr 1500 -> Rd returns 0.
3. Fetch address 2 holding 0x0000 -> o_halted=1 and o_cpu_rst=1 one cycle after o_instruc shows 0x0000. A WrRam issued after halt leaves memory unchanged.
4. In HALT, pulse i_dump_req; hold i_dump_ready low 3 cycles, then toggle it -> words 0..DATA_DEPTH-1 in order, with data stable while stalled. Word 5 = 0xBEEF, untouched words = 0. o_dump_last on word DATA_DEPTH-1, then back to HALT with valid=0.
5. Stream 2048 words without i_load_last -> auto-complete at address 2047; a 2049th valid is not accepted.
6. Assert i_rst mid-DUMP and mid-LOAD -> all outputs take reset values asynchronously. After release, state is LOAD with o_load_ready=1.
